// File: rtl/topk_result_drain.sv
// topk_result_drain
// Buffers one batch of top-k results while the search core is emitting, then
// drains the batch to a host consumer with programmable pacing and a
// valid/ready handshake. Reports entry index, batch completion, fill level and
// a sticky overflow flag.
// Build option: define RESULT_SORT_EN to keep the buffer ordered ascending by
// the low KEY_WIDTH bits of each result (shift-insert on capture). Without it
// the buffer is a plain FIFO and no key comparators exist.
module topk_result_drain #(
  parameter int                 DATA_WIDTH    = 32,
  parameter int                 DEPTH         = 8,
  parameter int                 STATE_W       = 3,
  parameter logic [STATE_W-1:0] CAPTURE_STATE = 3'b110,
  parameter logic [STATE_W-1:0] DRAIN_STATE   = 3'b111,
  parameter int                 KEY_WIDTH     = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [DATA_WIDTH-1:0]    result_in,
  input  logic                     result_valid_in,
  input  logic [STATE_W-1:0]       core_state_in,
  input  logic [31:0]              pace_div_in,
  input  logic                     host_ready_in,
  output logic [DATA_WIDTH-1:0]    result_out,
  output logic                     result_valid_out,
  output logic [$clog2(DEPTH)-1:0] index_out,
  output logic                     batch_done_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Reject configurations the pointer arithmetic and key slicing cannot support
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH) begin : g_bad_param
    $error("topk_result_drain: DEPTH must be a power of two >= 2 and KEY_WIDTH within DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [31:0]           pace_cnt;
  logic                  cap_hit;
  logic                  capture_phase;
  logic                  room;
  logic                  grow;
  logic                  mem_we;
  logic                  drop;

`ifdef RESULT_SORT_EN
  logic [CNT_W-1:0]      ins_pos;
  logic                  evict;

  // Find the slot after every stored entry whose key is <= the new key, and
  // decide whether a full buffer should give up its largest entry
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && mem[i][KEY_WIDTH-1:0] <= result_in[KEY_WIDTH-1:0]) begin
        ins_pos = ins_pos + CNT_W'(1);
      end
    end
    evict = result_in[KEY_WIDTH-1:0] < mem[DEPTH-1][KEY_WIDTH-1:0];
  end
`else
  logic [PTR_W-1:0]      wr_ptr;
`endif

  assign count_out = count_q;

  // Classify this cycle's core result: stored, stored by eviction, or dropped
  always_comb begin
    cap_hit       = (core_state_in == CAPTURE_STATE) && result_valid_in;
    capture_phase = (state == IDLE) || (state == CAPTURE);
    room          = count_q < CNT_W'(DEPTH);
    grow          = cap_hit && capture_phase && room;
`ifdef RESULT_SORT_EN
    mem_we        = grow || (cap_hit && capture_phase && !room && evict);
`else
    mem_we        = grow;
`endif
    drop          = cap_hit && !(capture_phase && room);
  end

  // Write captured words: append at the write pointer, or shift-insert by key
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
`ifdef RESULT_SORT_EN
      for (int i = DEPTH - 1; i > 0; i--) begin
        if (CNT_W'(i) > ins_pos) begin
          mem[i] <= mem[i-1];
        end
      end
      mem[ins_pos[PTR_W-1:0]] <= result_in;
`else
      mem[wr_ptr] <= result_in;
`endif
    end
  end

  // Batch FSM: capture, paced drain with handshake, one-cycle completion pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
`ifndef RESULT_SORT_EN
      wr_ptr           <= '0;
`endif
      rd_ptr           <= '0;
      count_q          <= '0;
      pace_cnt         <= '0;
      result_out       <= '0;
      result_valid_out <= 1'b0;
      index_out        <= '0;
      batch_done_out   <= 1'b0;
      overflow_out     <= 1'b0;
    end else begin
      if (drop) begin
        overflow_out <= 1'b1;
      end
      if (grow) begin
        count_q <= count_q + CNT_W'(1);
`ifndef RESULT_SORT_EN
        wr_ptr  <= wr_ptr + PTR_W'(1);
`endif
      end
      case (state)
        IDLE: begin
          if (grow) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (core_state_in == DRAIN_STATE && count_q != '0) begin
            state    <= DRAIN;
            pace_cnt <= '0;
          end
        end
        DRAIN: begin
          if (result_valid_out && host_ready_in) begin
            result_valid_out <= 1'b0;
            pace_cnt         <= '0;
            rd_ptr           <= rd_ptr + PTR_W'(1);
            count_q          <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state          <= DONE;
              batch_done_out <= 1'b1;
              index_out      <= '0;
            end else begin
              index_out <= index_out + PTR_W'(1);
            end
          end else begin
            if (pace_cnt != '1) begin
              pace_cnt <= pace_cnt + 32'd1;
            end
            if (!result_valid_out && pace_cnt >= pace_div_in) begin
              result_valid_out <= 1'b1;
              result_out       <= mem[rd_ptr];
            end
          end
        end
        DONE: begin
          batch_done_out <= 1'b0;
          state          <= IDLE;
`ifndef RESULT_SORT_EN
          wr_ptr         <= '0;
`endif
          rd_ptr         <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_result_drain.sv
// tb_topk_result_drain
// Scoreboard bench: every captured word is pushed into an expected queue by a
// reference model (FIFO, or key-ordered when RESULT_SORT_EN is defined) and
// popped by a monitor on each handshake accept.
module tb_topk_result_drain;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 8;
  localparam int STATE_W    = 3;
  localparam int KEY_WIDTH  = 16;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam logic [STATE_W-1:0] CAP = 3'b110;
  localparam logic [STATE_W-1:0] DRN = 3'b111;
  localparam logic [STATE_W-1:0] IDL = 3'b000;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic [DATA_WIDTH-1:0] result_in;
  logic                  result_valid_in;
  logic [STATE_W-1:0]    core_state_in;
  logic [31:0]           pace_div_in;
  logic                  host_ready_in;
  logic [DATA_WIDTH-1:0] result_out;
  logic                  result_valid_out;
  logic [PTR_W-1:0]      index_out;
  logic                  batch_done_out;
  logic [PTR_W:0]        count_out;
  logic                  overflow_out;

  int                    assert_cnt   = 0;
  int                    fail_cnt     = 0;
  int                    accepted_cnt = 0;
  int                    done_cnt     = 0;
  int                    exp_idx      = 0;
  logic                  model_ovf    = 1'b0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [DATA_WIDTH-1:0] exp_w;

  topk_result_drain #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DEPTH        (DEPTH),
    .STATE_W      (STATE_W),
    .CAPTURE_STATE(CAP),
    .DRAIN_STATE  (DRN),
    .KEY_WIDTH    (KEY_WIDTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .result_in       (result_in),
    .result_valid_in (result_valid_in),
    .core_state_in   (core_state_in),
    .pace_div_in     (pace_div_in),
    .host_ready_in   (host_ready_in),
    .result_out      (result_out),
    .result_valid_out(result_valid_out),
    .index_out       (index_out),
    .batch_done_out  (batch_done_out),
    .count_out       (count_out),
    .overflow_out    (overflow_out)
  );

  // 100 MHz style free-running clock
  always #5 clk_in = ~clk_in;

  // Hard stop in case the stimulus itself gets stuck
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model of what the buffer should hold after one more capture
  task automatic model_push(input logic [DATA_WIDTH-1:0] w);
`ifdef RESULT_SORT_EN
    int pos = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i][KEY_WIDTH-1:0] <= w[KEY_WIDTH-1:0]) pos = i + 1;
    end
    if (exp_q.size() < DEPTH) begin
      exp_q.insert(pos, w);
    end else begin
      model_ovf = 1'b1;
      if (w[KEY_WIDTH-1:0] < exp_q[DEPTH-1][KEY_WIDTH-1:0]) begin
        void'(exp_q.pop_back());
        exp_q.insert(pos, w);
      end
    end
`else
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else model_ovf = 1'b1;
`endif
  endtask

  task automatic applyStimulus(input logic [DATA_WIDTH-1:0] w);
    core_state_in   = CAP;
    result_in       = w;
    result_valid_in = 1'b1;
    model_push(w);
    tick();
    result_valid_in = 1'b0;
    core_state_in   = IDL;
  endtask

  // Drain monitor: compare every accepted entry against the scoreboard
  always @(negedge clk_in) begin
    if (!rst_in && result_valid_out && host_ready_in) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_entry", 64'(result_valid_out), 64'd0);
      end else begin
        exp_w = exp_q.pop_front();
        checkOutput("drain_data", 64'(result_out), 64'(exp_w));
        checkOutput("drain_index", 64'(index_out), 64'(exp_idx));
        exp_idx = (exp_q.size() == 0) ? 0 : exp_idx + 1;
        accepted_cnt++;
      end
    end
    if (batch_done_out) done_cnt++;
  end

  // Run the drain until batch_done_out, measuring valid spacing
  task automatic wait_done(input int max_cyc, output int first_rise, output int gap, output int alt_viol);
    int   rises       = 0;
    int   done_before = done_cnt;
    logic prev_v      = result_valid_out;
    logic finished    = 1'b0;
    first_rise = -1;
    gap        = -1;
    alt_viol   = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (result_valid_out && !prev_v) begin
        rises++;
        if (rises == 1) first_rise = c;
        else if (rises == 2) gap = c - first_rise;
      end
      if (result_valid_out && prev_v && host_ready_in) alt_viol++;
      prev_v = result_valid_out;
      if (batch_done_out) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      checkOutput("drain_timeout", 64'(batch_done_out), 64'd1);
    end else begin
      tick();
      checkOutput("done_single_pulse", 64'(batch_done_out), 64'd0);
      checkOutput("done_count", 64'(done_cnt - done_before), 64'd1);
      checkOutput("drain_count_empty", 64'(count_out), 64'd0);
      checkOutput("drain_index_home", 64'(index_out), 64'd0);
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    int first_rise, gap, alt, base, done_before;
    rst_in          = 1'b1;
    result_in       = '0;
    result_valid_in = 1'b0;
    core_state_in   = IDL;
    pace_div_in     = 32'd0;
    host_ready_in   = 1'b0;
    tick();
    tick();
    checkOutput("reset_valid", 64'(result_valid_out), 64'd0);
    checkOutput("reset_count", 64'(count_out), 64'd0);
    checkOutput("reset_overflow", 64'(overflow_out), 64'd0);
    checkOutput("reset_done", 64'(batch_done_out), 64'd0);
    checkOutput("reset_index", 64'(index_out), 64'd0);
    rst_in = 1'b0;
    tick();

    // Back-to-back drain of 5,7,1,1
    $display("[TB] batch: back-to-back drain");
    pace_div_in   = 32'd0;
    host_ready_in = 1'b1;
    applyStimulus(32'd5);
    applyStimulus(32'd7);
    applyStimulus(32'd1);
    applyStimulus(32'd1);
    checkOutput("t1_count", 64'(count_out), 64'd4);
    core_state_in = DRN;
    wait_done(60, first_rise, gap, alt);
    checkOutput("t1_first_delay", 64'(first_rise - 1), 64'd1);
    checkOutput("t1_gap", 64'(gap), 64'd2);
    checkOutput("t1_alternate", 64'(alt), 64'd0);
    checkOutput("t1_overflow", 64'(overflow_out), 64'(model_ovf));
    core_state_in = IDL;

    // Overfill: 10 words into 8 entries
    $display("[TB] batch: overfill");
    pace_div_in = 32'd1;
    for (int i = 1; i <= 10; i++) applyStimulus(32'(i));
    checkOutput("t2_count_full", 64'(count_out), 64'(DEPTH));
    checkOutput("t2_overflow", 64'(overflow_out), 64'(model_ovf));
    core_state_in = DRN;
    wait_done(100, first_rise, gap, alt);
    core_state_in = IDL;

    // Paced drain with pace_div_in = 4
    $display("[TB] batch: paced drain");
    pace_div_in = 32'd4;
    applyStimulus(32'h100);
    applyStimulus(32'h200);
    applyStimulus(32'h300);
    core_state_in = DRN;
    wait_done(100, first_rise, gap, alt);
    checkOutput("t3_first_delay", 64'(first_rise - 1), 64'd5);
    checkOutput("t3_gap", 64'(gap), 64'd6);
    core_state_in = IDL;

    // Host stalls 20 cycles with an entry presented
    $display("[TB] batch: host stall");
    pace_div_in   = 32'd0;
    host_ready_in = 1'b0;
    applyStimulus(32'hAA);
    applyStimulus(32'hBB);
    core_state_in = DRN;
    for (int c = 0; c < 20 && !result_valid_out; c++) tick();
    for (int c = 0; c < 20; c++) begin
      checkOutput("t4_hold_valid", 64'(result_valid_out), 64'd1);
      checkOutput("t4_hold_data", 64'(result_out), 64'hAA);
      checkOutput("t4_hold_index", 64'(index_out), 64'd0);
      checkOutput("t4_hold_count", 64'(count_out), 64'd2);
      tick();
    end
    host_ready_in = 1'b1;
    wait_done(60, first_rise, gap, alt);
    core_state_in = IDL;

    // Reset after 2 of 4 entries accepted
    $display("[TB] batch: reset mid-drain");
    applyStimulus(32'h11);
    applyStimulus(32'h22);
    applyStimulus(32'h33);
    applyStimulus(32'h44);
    core_state_in = DRN;
    base = accepted_cnt;
    for (int c = 0; c < 40 && (accepted_cnt - base) < 2; c++) tick();
    checkOutput("t5_two_accepted", 64'(accepted_cnt - base), 64'd2);
    done_before = done_cnt;
    rst_in = 1'b1;
    tick();
    exp_q.delete();
    exp_idx   = 0;
    model_ovf = 1'b0;
    checkOutput("t5_valid_cleared", 64'(result_valid_out), 64'd0);
    checkOutput("t5_count_cleared", 64'(count_out), 64'd0);
    checkOutput("t5_overflow_cleared", 64'(overflow_out), 64'(model_ovf));
    rst_in        = 1'b0;
    core_state_in = IDL;
    tick();
    tick();
    tick();
    checkOutput("t5_no_done", 64'(done_cnt - done_before), 64'd0);

    // New batch after reset; a result arriving mid-drain is dropped
    $display("[TB] batch: post-reset capture and drain-time drop");
    host_ready_in = 1'b0;
    applyStimulus(32'h55);
    applyStimulus(32'h66);
    core_state_in = DRN;
    tick();
    tick();
    core_state_in   = CAP;
    result_in       = 32'h77;
    result_valid_in = 1'b1;
    model_ovf       = 1'b1;
    tick();
    result_valid_in = 1'b0;
    core_state_in   = DRN;
    checkOutput("t6_drop_overflow", 64'(overflow_out), 64'(model_ovf));
    checkOutput("t6_drop_count", 64'(count_out), 64'd2);
    host_ready_in = 1'b1;
    wait_done(60, first_rise, gap, alt);
    core_state_in = IDL;

`ifdef RESULT_SORT_EN
    // Key ordering with duplicate keys keeping arrival order
    $display("[TB] batch: sorted capture");
    applyStimulus(32'hA0009);
    applyStimulus(32'hB0003);
    applyStimulus(32'hC0007);
    applyStimulus(32'hD0003);
    checkOutput("sort_head_model", 64'(exp_q[0]), 64'hB0003);
    core_state_in = DRN;
    wait_done(60, first_rise, gap, alt);
    core_state_in = IDL;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/topk_result_drain.md
Name: topk_result_drain

Overview:
- Parametrised successor to the fixed 8-deep, 32-bit top-k output buffer that sits between the bfis search core and the manta debug port.
- Captures one batch of top-k results while the core is in its emit state.
- Drains the batch to a host-side consumer with a programmable pace and a valid/ready handshake.
- Reports per-entry index, batch completion, fill level and a sticky overflow flag.

Parameters:
- DATA_WIDTH, 32, width of one result word.
- DEPTH, 8, batch buffer entries; power of two, at least 2.
- STATE_W, 3, width of the core state input.
- CAPTURE_STATE, 3'b110, core state in which valid results are captured.
- DRAIN_STATE, 3'b111, core state that arms the drain.
- KEY_WIDTH, 16, low bits of a result used as sort key (optional feature only).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- result_in  input  DATA_WIDTH  result word from search core
- result_valid_in  input  1  result_in valid this cycle
- core_state_in  input  STATE_W  current search core state
- pace_div_in  input  32  minimum idle cycles between drained entries; 0 = back-to-back
- host_ready_in  input  1  consumer accepts result_out this cycle
- result_out  output  DATA_WIDTH  drained entry
- result_valid_out  output  1  result_out valid
- index_out  output  $clog2(DEPTH)  position of result_out within batch, 0-based
- batch_done_out  output  1  one-cycle pulse after last entry accepted
- count_out  output  $clog2(DEPTH)+1  entries currently buffered
- overflow_out  output  1  sticky: a result was dropped

Behaviour:
- Interface: one clock, clk_in; rst_in synchronous active-high. Reset clears state to IDLE, buffer pointers, pace counter and all outputs.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE -> CAPTURE: first cycle with core_state_in==CAPTURE_STATE && result_valid_in. That word is written.
- CAPTURE write rule: every cycle with core_state_in==CAPTURE_STATE && result_valid_in writes one word while count_out<DEPTH.
- CAPTURE full: a write with count_out==DEPTH is dropped and sets overflow_out.
- CAPTURE -> DRAIN: core_state_in==DRAIN_STATE with count_out>0. With count_out==0, stay in CAPTURE.
- Pace counter: cleared on DRAIN entry and on each accepted entry; otherwise increments and saturates.
- Presenting: result_valid_out rises the cycle after the counter reaches pace_div_in. With pace_div_in=0, first valid is exactly 1 cycle after DRAIN entry.
- Holding: result_out, index_out and result_valid_out stay stable until host_ready_in. Accept happens on result_valid_out && host_ready_in.
- After accept: result_valid_out drops for at least one cycle, even when pace_div_in=0. count_out decrements and index_out increments.
- DRAIN -> DONE: accept of the last entry. batch_done_out =1 for exactly one cycle in DONE, then IDLE. index_out returns to 0.
- Result writes while in DRAIN or DONE are dropped and set overflow_out.
- overflow_out clears only on rst_in.
- Wrap: write and read pointers wrap modulo DEPTH; count_out never exceeds DEPTH.
- pace_div_in is sampled continuously. Changing it mid-drain affects only the next comparison.
- Reset mid-drain: outputs deassert the next cycle, buffer is emptied and no batch_done_out is issued.

Optional Feature:
- Macro: RESULT_SORT_EN.
- Defined: each capture inserts into the buffer ordered ascending by result_in[KEY_WIDTH-1:0], using a one-cycle shift-insert. Equal keys keep arrival order. When full, a new word with key below the current maximum evicts the maximum and sets overflow_out; otherwise the new word is dropped and sets overflow_out. Drain order is ascending key.
- Undefined: plain FIFO order, no comparators synthesised.

Test Plan:
- pace_div_in=0, capture 5,7,1,1 then DRAIN_STATE, host_ready_in=1 -> result_out 5,7,1,1 on alternate cycles; index_out 0..3; batch_done_out one pulse; count_out 0.
- DEPTH=8, capture 10 words 1..10 -> count_out=8, overflow_out=1, drained 1..8.
- pace_div_in=4, 3 entries, host_ready_in=1 -> valid edges spaced 6 cycles apart; first valid 5 cycles after DRAIN entry.
- host_ready_in held low 20 cycles with an entry presented -> result_out and index_out stable; count_out unchanged.
- rst_in pulsed mid-drain after 2 of 4 accepted -> result_valid_out=0, count_out=0 the next cycle; no batch_done_out; new batch captures normally.
- RESULT_SORT_EN, capture keys 9,3,7,3 -> drained 3,3,7,9, with the first-arrived 3 first.
